// File: rtl/score_keeper.sv
// Pong score keeper: detects goal-line misses from the ball x position, keeps both
// scores and sequences serve / hold / game-over for the top level.
module score_keeper #(
    parameter int BALL_SIZE      = 10,
    parameter int LEFT_BOUNDARY  = 3,
    parameter int RIGHT_BOUNDARY = 637,
    parameter int WIN_SCORE      = 7,
    parameter int HOLD_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ball_pos_x,
    input  logic        game_start,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        point_left,
    output logic        point_right,
    output logic        serve_req,
    output logic        game_over,
    output logic        winner
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [3:0]       WIN_VAL  = 4'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [11:0]      right_edge;
    logic             miss_l;
    logic             miss_r;
    logic [3:0]       score_left_nxt;
    logic [3:0]       score_right_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == HOLD_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Right edge computed one bit wider than the position so it cannot wrap.
    always_comb begin
        right_edge      = {1'b0, ball_pos_x} + 12'(BALL_SIZE);
        miss_l          = (ball_pos_x <= 11'(LEFT_BOUNDARY));
        miss_r          = (right_edge >= 12'(RIGHT_BOUNDARY));
        score_left_nxt  = score_left + 4'd1;
        score_right_nxt = score_right + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            point_left  <= 1'b0;
            point_right <= 1'b0;
            serve_req   <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            point_left  <= 1'b0;
            point_right <= 1'b0;
            serve_req   <= 1'b0;
            case (state)
                IDLE: begin
                    score_left  <= 4'd0;
                    score_right <= 4'd0;
                    if (game_start) state <= PLAY;
                end
                PLAY: begin
                    // Left miss wins if a misconfiguration makes both zones overlap.
                    if (miss_l) begin
                        score_right <= score_right_nxt;
                        point_right <= 1'b1;
                        hold_cnt    <= '0;
                        if (score_right_nxt == WIN_VAL) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (miss_r) begin
                        score_left <= score_left_nxt;
                        point_left <= 1'b1;
                        hold_cnt   <= '0;
                        if (score_left_nxt == WIN_VAL) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Only serve once the ball has left both goal zones.
                    if (hold_cnt == HOLD_MAX && !miss_l && !miss_r) begin
                        serve_req <= 1'b1;
                        state     <= PLAY;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                    end
                end
                OVER: begin
                    if (game_start) begin
                        score_left  <= 4'd0;
                        score_right <= 4'd0;
                        game_over   <= 1'b0;
                        serve_req   <= 1'b1;
                        state       <= PLAY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with short hold and low win score; a second
// instance with overlapping goal zones covers the left-priority rule.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] ball_pos_x;
    logic [10:0] ball_pos_x2;
    logic        game_start;

    logic [3:0]  score_left, score_right;
    logic        point_left, point_right, serve_req, game_over, winner;
    logic [3:0]  o_score_left, o_score_right;
    logic        o_point_left, o_point_right, o_serve_req, o_game_over, o_winner;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    score_keeper #(
        .BALL_SIZE(10), .LEFT_BOUNDARY(3), .RIGHT_BOUNDARY(637),
        .WIN_SCORE(3), .HOLD_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .ball_pos_x(ball_pos_x), .game_start(game_start),
        .score_left(score_left), .score_right(score_right),
        .point_left(point_left), .point_right(point_right),
        .serve_req(serve_req), .game_over(game_over), .winner(winner)
    );

    score_keeper #(
        .BALL_SIZE(10), .LEFT_BOUNDARY(3), .RIGHT_BOUNDARY(10),
        .WIN_SCORE(3), .HOLD_CYCLES(4)
    ) u_ovl (
        .clk(clk), .reset(reset), .ball_pos_x(ball_pos_x2), .game_start(game_start),
        .score_left(o_score_left), .score_right(o_score_right),
        .point_left(o_point_left), .point_right(o_point_right),
        .serve_req(o_serve_req), .game_over(o_game_over), .winner(o_winner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps until serve_req is seen (bounded); returns ticks taken, 0 on timeout.
    task automatic wait_serve(output int n);
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (serve_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ball_pos_x = 11'd320; ball_pos_x2 = 11'd0; game_start = 1'b0;
        tick(); tick();
        vectors++;
        if ({score_left, score_right} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_scores: got %h want 00", {score_left, score_right});
        end
        vectors++;
        if ({point_left, point_right, serve_req, game_over, winner} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000",
                     {point_left, point_right, serve_req, game_over, winner});
        end
        reset = 1'b1;
        ball_pos_x = 11'd3;
        tick();
        vectors++;
        if (point_right !== 1'b0 || score_right !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_ignores_miss: point_right=%b score_right=%0d want 0/0",
                     point_right, score_right);
        end
        ball_pos_x = 11'd320;
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        vectors++;
        if ({point_left, point_right, serve_req} !== 3'b000) begin
            miscompares++;
            $display("FAIL start_no_pulse: got %b want 000", {point_left, point_right, serve_req});
        end
        tick(); tick();
        vectors++;
        if ({point_left, point_right, serve_req, score_left, score_right} !== 11'd0) begin
            miscompares++;
            $display("FAIL play_center_quiet: got %h want 000",
                     {point_left, point_right, serve_req, score_left, score_right});
        end
    endtask

    task automatic test_left_miss();
        int pr_cnt, sr_cnt, n;
        pr_cnt = 0; sr_cnt = 0;
        ball_pos_x = 11'd3;
        tick();
        vectors++;
        if (point_right !== 1'b1 || score_right !== 4'd1) begin
            miscompares++;
            $display("FAIL left_miss_first_edge: point_right=%b score_right=%0d want 1/1",
                     point_right, score_right);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            pr_cnt += int'(point_right);
            sr_cnt += int'(serve_req);
        end
        vectors++;
        if (pr_cnt !== 0 || sr_cnt !== 0 || score_right !== 4'd1) begin
            miscompares++;
            $display("FAIL hold_in_goal: extra_points=%0d serves=%0d score_right=%0d want 0/0/1",
                     pr_cnt, sr_cnt, score_right);
        end
        ball_pos_x = 11'd320;
        tick();
        vectors++;
        if (serve_req !== 1'b1) begin
            miscompares++;
            $display("FAIL serve_after_clear: serve_req=%b want 1", serve_req);
        end
        tick();
        vectors++;
        if ({serve_req, point_left, point_right} !== 3'b000) begin
            miscompares++;
            $display("FAIL serve_single_pulse: got %b want 000", {serve_req, point_left, point_right});
        end
        n = 0;
        if (n != 0) $display("unused");
    endtask

    task automatic test_right_boundary();
        int n;
        ball_pos_x = 11'd626;
        tick(); tick();
        vectors++;
        if (point_left !== 1'b0 || score_left !== 4'd0) begin
            miscompares++;
            $display("FAIL right_edge_636: point_left=%b score_left=%0d want 0/0", point_left, score_left);
        end
        ball_pos_x = 11'd627;
        tick();
        vectors++;
        if ({point_left, point_right, score_left} !== {1'b1, 1'b0, 4'd1}) begin
            miscompares++;
            $display("FAIL right_edge_637: pl/pr/score_left=%b%b/%0d want 10/1",
                     point_left, point_right, score_left);
        end
        ball_pos_x = 11'd320;
        wait_serve(n);
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL hold_length: serve after %0d cycles want 5", n);
        end
    endtask

    task automatic test_game_over();
        int n, pulses;
        pulses = 0;
        ball_pos_x = 11'd3;
        tick();
        vectors++;
        if (point_right !== 1'b1 || score_right !== 4'd2 || game_over !== 1'b0) begin
            miscompares++;
            $display("FAIL second_point: pr=%b score_right=%0d go=%b want 1/2/0",
                     point_right, score_right, game_over);
        end
        ball_pos_x = 11'd320;
        wait_serve(n);
        vectors++;
        if (n !== 5) begin
            miscompares++;
            $display("FAIL hold_length2: serve after %0d cycles want 5", n);
        end
        ball_pos_x = 11'd3;
        tick();
        vectors++;
        if ({point_right, score_right, game_over, winner} !== {1'b1, 4'd3, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL winning_point: pr/score_right/go/winner=%b/%0d/%b/%b want 1/3/1/1",
                     point_right, score_right, game_over, winner);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(point_left) + int'(point_right) + int'(serve_req);
        end
        ball_pos_x = 11'd627;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(point_left) + int'(point_right) + int'(serve_req);
        end
        vectors++;
        if (pulses !== 0 || {score_left, score_right} !== {4'd1, 4'd3} ||
            game_over !== 1'b1 || winner !== 1'b1) begin
            miscompares++;
            $display("FAIL over_frozen: pulses=%0d scores=%0d/%0d go=%b winner=%b want 0/1/3/1/1",
                     pulses, score_left, score_right, game_over, winner);
        end
        ball_pos_x = 11'd320;
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        vectors++;
        if ({score_left, score_right, game_over, serve_req} !== {8'h00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL restart: scores=%0d/%0d go=%b serve=%b want 0/0/0/1",
                     score_left, score_right, game_over, serve_req);
        end
    endtask

    task automatic test_hold_reset();
        int n, serves;
        serves = 0;
        ball_pos_x = 11'd627;
        tick();
        ball_pos_x = 11'd320;
        wait_serve(n);
        ball_pos_x = 11'd627;
        tick();
        vectors++;
        if (score_left !== 4'd2 || point_left !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_score: score_left=%0d pl=%b want 2/1", score_left, point_left);
        end
        ball_pos_x = 11'd320;
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        vectors++;
        if ({score_left, score_right, point_left, point_right, serve_req, game_over} !== 12'd0) begin
            miscompares++;
            $display("FAIL mid_hold_reset: got %h want 000",
                     {score_left, score_right, point_left, point_right, serve_req, game_over});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            serves += int'(serve_req);
        end
        ball_pos_x = 11'd3;
        tick();
        vectors++;
        if (serves !== 0 || point_right !== 1'b0 || score_right !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_to_idle: serves=%0d pr=%b score_right=%0d want 0/0/0",
                     serves, point_right, score_right);
        end
        ball_pos_x = 11'd320;
    endtask

    task automatic test_overlap();
        ball_pos_x2 = 11'd0;
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        tick();
        vectors++;
        if ({o_point_right, o_point_left, o_score_right, o_score_left} !== {1'b1, 1'b0, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL overlap_left_priority: pr/pl/sr/sl=%b/%b/%0d/%0d want 1/0/1/0",
                     o_point_right, o_point_left, o_score_right, o_score_left);
        end
    endtask

    initial begin
        test_reset();
        test_left_miss();
        test_right_boundary();
        test_game_over();
        test_hold_reset();
        test_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
